interface_tag_responder: RTL and testbench

// - Memory-side end of the tagged request/response protocol: accepts tagged read requests
//   (ea, tag) and returns (tag, data) responses after a programmable latency.
// - Stands in for the OpenCAPI host/L2 in stream-cache benches and FPGA loopback builds.
// - Also audits tag usage: duplicate in-flight tags are flagged.

---
 rtl/tag_if_pkg.sv | 29 ++
 rtl/tag_rsp_buf.sv | 40 ++++
 rtl/interface_tag_responder.sv | 115 +++++++++++
 tb/tb_interface_tag_responder.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tag_if_pkg.sv
// Shared types and helpers for the tagged request/response protocol.
// The initiator bench and the responder both take their defaults from here.
package tag_if_pkg;

    localparam int unsigned ea_width   = 64;
    localparam int unsigned rsp_width  = 1024;
    localparam int unsigned tag_space  = 256;
    localparam int unsigned tag_width  = $clog2(tag_space);
    localparam int unsigned ts_width   = 8;
    localparam int unsigned buf_depth  = 16;
    localparam int unsigned lane_count = rsp_width / ea_width;

    typedef struct packed {
        logic [ea_width-1:0]  ea;
        logic [tag_width-1:0] tag;
        logic [ts_width-1:0]  due;
    } req_t;

    // Response pattern: lane k carries ea + k
    function automatic logic [rsp_width-1:0] lane_data(input logic [ea_width-1:0] ea);
        logic [rsp_width-1:0] d;
        d = '0;
        for (int unsigned k = 0; k < lane_count; k++) begin
            d[k*ea_width +: ea_width] = ea + ea_width'(k);
        end
        return d;
    endfunction

endpackage

// File: rtl/tag_rsp_buf.sv
// Circular buffer of outstanding requests; pointers carry an extra wrap bit
// so that count distinguishes full from empty.
module tag_rsp_buf #(
    parameter int unsigned width = 8,
    parameter int unsigned depth = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [width-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [width-1:0]       rd_data,
    output logic [$clog2(depth):0] count
);

    localparam int unsigned aw = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [aw:0]      head;
    logic [aw:0]      tail;

    always_ff @(posedge clk) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (wr_en) tail <= tail + (aw+1)'(1);
            if (rd_en) head <= head + (aw+1)'(1);
        end
    end

    // Storage needs no reset; only pointers define validity
    always_ff @(posedge clk) begin
        if (wr_en) mem[tail[aw-1:0]] <= wr_data;
    end

    assign rd_data = mem[head[aw-1:0]];
    assign count   = tail - head;

endmodule

// File: rtl/interface_tag_responder.sv
// Memory-side responder: returns (tag, data) for each tagged read request after a
// per-request latency, strictly in order, and flags duplicate in-flight tags.
module interface_tag_responder
    import tag_if_pkg::*;
#(
    parameter int unsigned addr_width = ea_width,
    parameter int unsigned data_width = rsp_width,
    parameter int unsigned tag        = tag_space,
    parameter int unsigned depth      = buf_depth,
    parameter int unsigned lat_width  = ts_width
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [lat_width-1:0]    i_lat,
    input  logic                    i_req_v,
    output logic                    i_req_r,
    input  logic [addr_width-1:0]   i_req_ea,
    input  logic [$clog2(tag)-1:0]  i_req_tag,
    output logic                    o_rsp_v,
    input  logic                    o_rsp_r,
    output logic [$clog2(tag)-1:0]  o_rsp_tag,
    output logic [data_width-1:0]   o_rsp_data,
    output logic [$clog2(depth):0]  o_inflight,
    output logic                    o_err_dup
);

    localparam int unsigned tag_bits  = $clog2(tag);
    localparam int unsigned cnt_width = $clog2(depth) + 1;
    localparam int unsigned lanes     = data_width / addr_width;
    localparam int unsigned ent_width = addr_width + tag_bits + lat_width;

    logic [lat_width-1:0]  now;
    logic                  accept;
    logic                  rsp_fire;
    logic                  load;
    logic [ent_width-1:0]  wr_ent;
    logic [ent_width-1:0]  head_ent;
    logic [cnt_width-1:0]  buf_count;
    logic [addr_width-1:0] head_ea;
    logic [tag_bits-1:0]   head_tag;
    logic [lat_width-1:0]  head_due;
    logic [lat_width-1:0]  age;
    logic                  head_ready;
    logic [data_width-1:0] head_data;
    logic [tag-1:0]        busy;

    // Ready counts the output register too, so o_inflight never exceeds depth
    assign i_req_r  = (o_inflight != cnt_width'(depth));
    assign accept   = i_req_v & i_req_r;
    assign rsp_fire = o_rsp_v & o_rsp_r;
    assign wr_ent   = {i_req_ea, i_req_tag, lat_width'(now + i_lat)};

    tag_rsp_buf #(
        .width (ent_width),
        .depth (depth)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (accept),
        .wr_data (wr_ent),
        .rd_en   (load),
        .rd_data (head_ent),
        .count   (buf_count)
    );

    // Wrap-safe due check: head is ripe once now has reached due within half the range
    assign {head_ea, head_tag, head_due} = head_ent;
    assign age        = now - head_due;
    assign head_ready = (buf_count != '0) & ~age[lat_width-1];
    assign load       = head_ready & (~o_rsp_v | o_rsp_r);

    always_comb begin
        head_data = '0;
        for (int unsigned k = 0; k < lanes; k++) begin
            head_data[k*addr_width +: addr_width] = head_ea + addr_width'(k);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            now        <= '0;
            o_rsp_v    <= 1'b0;
            o_rsp_tag  <= '0;
            o_rsp_data <= '0;
            o_inflight <= '0;
            o_err_dup  <= 1'b0;
            busy       <= '0;
        end else begin
            now <= now + lat_width'(1);

            if (load) begin
                o_rsp_v    <= 1'b1;
                o_rsp_tag  <= head_tag;
                o_rsp_data <= head_data;
            end else if (rsp_fire) begin
                o_rsp_v <= 1'b0;
            end

            if (accept && !rsp_fire) begin
                o_inflight <= o_inflight + cnt_width'(1);
            end else if (!accept && rsp_fire) begin
                o_inflight <= o_inflight - cnt_width'(1);
            end

            // Set after clear so a tag reissued on its release cycle stays busy
            if (rsp_fire) busy[o_rsp_tag] <= 1'b0;
            if (accept)   busy[i_req_tag] <= 1'b1;

            if (accept && busy[i_req_tag] && !(rsp_fire && (o_rsp_tag == i_req_tag))) begin
                o_err_dup <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_interface_tag_responder.sv
// Bench for interface_tag_responder: directed scenarios plus a randomized run
// checked against a queue-based reference model using absolute cycle times.
module tb_interface_tag_responder;

    logic          clk;
    logic          reset;
    logic [7:0]    i_lat;
    logic          i_req_v;
    logic          i_req_r;
    logic [63:0]   i_req_ea;
    logic [7:0]    i_req_tag;
    logic          o_rsp_v;
    logic          o_rsp_r;
    logic [7:0]    o_rsp_tag;
    logic [1023:0] o_rsp_data;
    logic [4:0]    o_inflight;
    logic          o_err_dup;

    logic          reset2;
    logic [3:0]    w_lat;
    logic          w_req_v;
    logic          w_req_r;
    logic [15:0]   w_ea;
    logic [3:0]    w_tag;
    logic          w_rsp_v;
    logic          w_rsp_r;
    logic [3:0]    w_rsp_tag;
    logic [63:0]   w_rsp_data;
    logic [2:0]    w_inflight;
    logic          w_err_dup;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [63:0] ea;
        logic [7:0]  tag;
        int          rel;
    } pend_t;

    interface_tag_responder dut (
        .clk        (clk),
        .reset      (reset),
        .i_lat      (i_lat),
        .i_req_v    (i_req_v),
        .i_req_r    (i_req_r),
        .i_req_ea   (i_req_ea),
        .i_req_tag  (i_req_tag),
        .o_rsp_v    (o_rsp_v),
        .o_rsp_r    (o_rsp_r),
        .o_rsp_tag  (o_rsp_tag),
        .o_rsp_data (o_rsp_data),
        .o_inflight (o_inflight),
        .o_err_dup  (o_err_dup)
    );

    interface_tag_responder #(
        .addr_width (16),
        .data_width (64),
        .tag        (16),
        .depth      (4),
        .lat_width  (4)
    ) dut2 (
        .clk        (clk),
        .reset      (reset2),
        .i_lat      (w_lat),
        .i_req_v    (w_req_v),
        .i_req_r    (w_req_r),
        .i_req_ea   (w_ea),
        .i_req_tag  (w_tag),
        .o_rsp_v    (w_rsp_v),
        .o_rsp_r    (w_rsp_r),
        .o_rsp_tag  (w_rsp_tag),
        .o_rsp_data (w_rsp_data),
        .o_inflight (w_inflight),
        .o_err_dup  (w_err_dup)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        reset   = 1'b1;
        i_req_v = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Drives one request for one cycle; caller guarantees ready
    task automatic send(input logic [63:0] ea, input logic [7:0] tag, input logic [7:0] lat);
        i_req_v   = 1'b1;
        i_req_ea  = ea;
        i_req_tag = tag;
        i_lat     = lat;
        @(negedge clk);
        i_req_v = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks += 4;
        if (o_rsp_v !== 1'b0) begin n_fail++; $display("FAIL reset_v: got %b expected 0", o_rsp_v); end
        if (o_inflight !== 5'd0) begin n_fail++; $display("FAIL reset_inflight: got %0d expected 0", o_inflight); end
        if (o_err_dup !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", o_err_dup); end
        if (i_req_r !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", i_req_r); end
    endtask

    task automatic test_single();
        int lat_obs;
        do_reset();
        o_rsp_r = 1'b1;
        send(64'h1000, 8'd5, 8'd4);
        lat_obs = 0;
        while (!o_rsp_v && lat_obs < 100) begin
            @(negedge clk);
            lat_obs++;
        end
        n_checks += 4;
        if (lat_obs != 4) begin n_fail++; $display("FAIL single_latency: got %0d expected 4", lat_obs); end
        if (o_rsp_tag !== 8'd5) begin n_fail++; $display("FAIL single_tag: got %0d expected 5", o_rsp_tag); end
        if (o_rsp_data[63:0] !== 64'h1000) begin n_fail++; $display("FAIL single_lane0: got %h expected 1000", o_rsp_data[63:0]); end
        if (o_rsp_data[15*64 +: 64] !== 64'h100F) begin n_fail++; $display("FAIL single_lane15: got %h expected 100f", o_rsp_data[15*64 +: 64]); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [63:0] eas [16];
        do_reset();
        o_rsp_r = 1'b0;
        for (int i = 0; i < 16; i++) begin
            eas[i] = {$urandom, $urandom};
            send(eas[i], 8'(i), 8'd1);
        end
        n_checks += 2;
        if (i_req_r !== 1'b0) begin n_fail++; $display("FAIL b2b_full_ready: got %b expected 0", i_req_r); end
        if (o_inflight !== 5'd16) begin n_fail++; $display("FAIL b2b_inflight: got %0d expected 16", o_inflight); end
        o_rsp_r = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_checks += 3;
            if (o_rsp_v !== 1'b1) begin n_fail++; $display("FAIL b2b_v[%0d]: got %b expected 1", i, o_rsp_v); end
            if (o_rsp_tag !== 8'(i)) begin n_fail++; $display("FAIL b2b_tag[%0d]: got %0d expected %0d", i, o_rsp_tag, i); end
            if (o_rsp_data[63:0] !== eas[i]) begin n_fail++; $display("FAIL b2b_lane0[%0d]: got %h expected %h", i, o_rsp_data[63:0], eas[i]); end
            @(negedge clk);
            if (i == 0) begin
                n_checks++;
                if (i_req_r !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_back: got %b expected 1", i_req_r); end
            end
        end
        n_checks += 2;
        if (o_rsp_v !== 1'b0) begin n_fail++; $display("FAIL b2b_drained_v: got %b expected 0", o_rsp_v); end
        if (o_inflight !== 5'd0) begin n_fail++; $display("FAIL b2b_drained_inflight: got %0d expected 0", o_inflight); end
    endtask

    task automatic test_latency_change();
        int lat_obs;
        do_reset();
        o_rsp_r = 1'b1;
        send(64'hA000, 8'd1, 8'd10);
        send(64'hB000, 8'd2, 8'd1);
        lat_obs = 1;
        while (!o_rsp_v && lat_obs < 100) begin
            @(negedge clk);
            lat_obs++;
        end
        n_checks += 2;
        if (lat_obs != 10) begin n_fail++; $display("FAIL latchg_a_latency: got %0d expected 10", lat_obs); end
        if (o_rsp_tag !== 8'd1) begin n_fail++; $display("FAIL latchg_a_tag: got %0d expected 1", o_rsp_tag); end
        @(negedge clk);
        n_checks += 3;
        if (o_rsp_v !== 1'b1) begin n_fail++; $display("FAIL latchg_b_v: got %b expected 1", o_rsp_v); end
        if (o_rsp_tag !== 8'd2) begin n_fail++; $display("FAIL latchg_b_tag: got %0d expected 2", o_rsp_tag); end
        if (o_rsp_data[63:0] !== 64'hB000) begin n_fail++; $display("FAIL latchg_b_lane0: got %h expected b000", o_rsp_data[63:0]); end
        @(negedge clk);
        n_checks++;
        if (o_rsp_v !== 1'b0) begin n_fail++; $display("FAIL latchg_idle: got %b expected 0", o_rsp_v); end
    endtask

    // Narrow instance: request accepted when its 4-bit timestamp reads 14, due wraps to 3
    task automatic test_wrap();
        int lat_obs;
        reset2  = 1'b1;
        w_req_v = 1'b0;
        w_rsp_r = 1'b1;
        @(negedge clk);
        reset2 = 1'b0;
        repeat (14) @(negedge clk);
        w_req_v = 1'b1;
        w_ea    = 16'hABCD;
        w_tag   = 4'd9;
        w_lat   = 4'd5;
        @(negedge clk);
        w_req_v = 1'b0;
        lat_obs = 0;
        while (!w_rsp_v && lat_obs < 50) begin
            @(negedge clk);
            lat_obs++;
        end
        n_checks += 3;
        if (lat_obs != 5) begin n_fail++; $display("FAIL wrap_latency: got %0d expected 5", lat_obs); end
        if (w_rsp_tag !== 4'd9) begin n_fail++; $display("FAIL wrap_tag: got %0d expected 9", w_rsp_tag); end
        if (w_rsp_data[48 +: 16] !== 16'hABD0) begin n_fail++; $display("FAIL wrap_lane3: got %h expected abd0", w_rsp_data[48 +: 16]); end
        @(negedge clk);
    endtask

    task automatic test_dup();
        int wait_cnt;
        do_reset();
        o_rsp_r = 1'b0;
        send(64'h7000, 8'd7, 8'd20);
        n_checks++;
        if (o_err_dup !== 1'b0) begin n_fail++; $display("FAIL dup_first_clean: got %b expected 0", o_err_dup); end
        send(64'h7100, 8'd7, 8'd20);
        n_checks++;
        if (o_err_dup !== 1'b1) begin n_fail++; $display("FAIL dup_flag: got %b expected 1", o_err_dup); end
        o_rsp_r  = 1'b1;
        wait_cnt = 0;
        while (!o_rsp_v && wait_cnt < 100) begin
            @(negedge clk);
            wait_cnt++;
        end
        n_checks += 2;
        if (o_rsp_tag !== 8'd7 || o_rsp_data[63:0] !== 64'h7000) begin
            n_fail++; $display("FAIL dup_first_rsp: got tag %0d ea %h expected tag 7 ea 7000", o_rsp_tag, o_rsp_data[63:0]);
        end
        @(negedge clk);
        if (o_rsp_v !== 1'b1 || o_rsp_tag !== 8'd7 || o_rsp_data[63:0] !== 64'h7100) begin
            n_fail++; $display("FAIL dup_second_rsp: got v %b tag %0d ea %h expected v 1 tag 7 ea 7100", o_rsp_v, o_rsp_tag, o_rsp_data[63:0]);
        end
        @(negedge clk);
        n_checks++;
        if (o_err_dup !== 1'b1) begin n_fail++; $display("FAIL dup_sticky: got %b expected 1", o_err_dup); end

        do_reset();
        o_rsp_r = 1'b1;
        send(64'h7200, 8'd7, 8'd3);
        wait_cnt = 0;
        while (!o_rsp_v && wait_cnt < 100) begin
            @(negedge clk);
            wait_cnt++;
        end
        send(64'h7300, 8'd7, 8'd3);
        n_checks++;
        if (o_err_dup !== 1'b0) begin n_fail++; $display("FAIL dup_release_cycle: got %b expected 0", o_err_dup); end
        wait_cnt = 0;
        while (!o_rsp_v && wait_cnt < 100) begin
            @(negedge clk);
            wait_cnt++;
        end
        n_checks += 2;
        if (o_rsp_tag !== 8'd7 || o_rsp_data[63:0] !== 64'h7300) begin
            n_fail++; $display("FAIL dup_reissue_rsp: got tag %0d ea %h expected tag 7 ea 7300", o_rsp_tag, o_rsp_data[63:0]);
        end
        if (o_err_dup !== 1'b0) begin n_fail++; $display("FAIL dup_reissue_err: got %b expected 0", o_err_dup); end
        @(negedge clk);
    endtask

    task automatic test_reset_midop();
        logic stale;
        do_reset();
        o_rsp_r = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send({$urandom, $urandom}, (i < 2) ? 8'd3 : 8'(10 + i), 8'd40);
        end
        n_checks += 2;
        if (o_inflight !== 5'd6) begin n_fail++; $display("FAIL midop_pending: got %0d expected 6", o_inflight); end
        if (o_err_dup !== 1'b1) begin n_fail++; $display("FAIL midop_err_before: got %b expected 1", o_err_dup); end
        do_reset();
        n_checks += 3;
        if (o_rsp_v !== 1'b0) begin n_fail++; $display("FAIL midop_v: got %b expected 0", o_rsp_v); end
        if (o_inflight !== 5'd0) begin n_fail++; $display("FAIL midop_inflight: got %0d expected 0", o_inflight); end
        if (o_err_dup !== 1'b0) begin n_fail++; $display("FAIL midop_err: got %b expected 0", o_err_dup); end
        o_rsp_r = 1'b1;
        stale   = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (o_rsp_v) stale = 1'b1;
        end
        n_checks++;
        if (stale !== 1'b0) begin n_fail++; $display("FAIL midop_stale: got %b expected 0", stale); end
    endtask

    task automatic test_random();
        pend_t         q[$];
        pend_t         p;
        logic          mv;
        logic [7:0]    mtag;
        logic [63:0]   mea;
        int            minf;
        logic          merr;
        logic          mbusy [256];
        logic [1023:0] ed;
        logic          acc;
        logic          fire;
        do_reset();
        mv   = 1'b0;
        mtag = '0;
        mea  = '0;
        minf = 0;
        merr = 1'b0;
        for (int i = 0; i < 256; i++) mbusy[i] = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            n_checks += 4;
            if (o_rsp_v !== mv) begin n_fail++; $display("FAIL rand_v @%0d: got %b expected %b", cyc, o_rsp_v, mv); end
            if (o_inflight !== 5'(minf)) begin n_fail++; $display("FAIL rand_inflight @%0d: got %0d expected %0d", cyc, o_inflight, minf); end
            if (o_err_dup !== merr) begin n_fail++; $display("FAIL rand_err @%0d: got %b expected %b", cyc, o_err_dup, merr); end
            if (i_req_r !== (minf != 16)) begin n_fail++; $display("FAIL rand_ready @%0d: got %b expected %b", cyc, i_req_r, minf != 16); end
            if (mv) begin
                for (int k = 0; k < 16; k++) ed[k*64 +: 64] = mea + 64'(k);
                n_checks += 2;
                if (o_rsp_tag !== mtag) begin n_fail++; $display("FAIL rand_tag @%0d: got %0d expected %0d", cyc, o_rsp_tag, mtag); end
                if (o_rsp_data !== ed) begin
                    n_fail++;
                    for (int k = 0; k < 16; k++) begin
                        if (o_rsp_data[k*64 +: 64] !== ed[k*64 +: 64]) begin
                            $display("FAIL rand_data @%0d lane %0d: got %h expected %h", cyc, k, o_rsp_data[k*64 +: 64], ed[k*64 +: 64]);
                            break;
                        end
                    end
                end
            end

            i_req_v   = ($urandom_range(0, 99) < 60);
            i_req_ea  = {$urandom, $urandom};
            i_req_tag = 8'($urandom_range(0, 31));
            i_lat     = 8'($urandom_range(1, 12));
            o_rsp_r   = ($urandom_range(0, 99) < 70);

            // Reference: what the next clock edge does, in absolute cycle time
            fire = mv && o_rsp_r;
            acc  = i_req_v && (minf != 16);
            if (acc && mbusy[i_req_tag] && !(fire && mtag == i_req_tag)) merr = 1'b1;
            if (fire) begin
                mbusy[mtag] = 1'b0;
                mv = 1'b0;
            end
            if (acc) mbusy[i_req_tag] = 1'b1;
            if (!mv && q.size() > 0 && q[0].rel <= cyc) begin
                p    = q.pop_front();
                mv   = 1'b1;
                mtag = p.tag;
                mea  = p.ea;
            end
            if (acc) q.push_back('{ea: i_req_ea, tag: i_req_tag, rel: cyc + int'(i_lat)});
            minf = minf + int'(acc) - int'(fire);
            @(negedge clk);
        end
        i_req_v = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        i_lat     = 8'd1;
        i_req_v   = 1'b0;
        i_req_ea  = '0;
        i_req_tag = '0;
        o_rsp_r   = 1'b0;
        reset2    = 1'b1;
        w_lat     = 4'd1;
        w_req_v   = 1'b0;
        w_ea      = '0;
        w_tag     = '0;
        w_rsp_r   = 1'b0;

        test_reset();
        test_single();
        test_back_to_back();
        test_latency_change();
        test_wrap();
        test_dup();
        test_reset_midop();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
